vend_controller: RTL and testbench

Parametrised multi-product vending controller, successor to the three-product `drink_machine`. It accepts nickel, dime and quarter coins, keeps a running credit, and vends the lowest-indexed affordable, in-stock selection. Optionally it returns change as nickel pulses. It sits between the coin acceptor/selection panel and the dispenser and change-hopper drivers.

---
 rtl/vend_pkg.sv | 29 ++
 rtl/vend_stock.sv | 26 ++
 rtl/vend_controller.sv | 190 +++++++++++++++++++
 tb/tb_vend_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for vend_controller: coin encoding, coin values in nickel units
// and the controller state encoding.
package vend_pkg;

    localparam int unsigned COIN_W     = 2;
    localparam int unsigned COIN_VAL_W = 3;

    localparam logic [COIN_W-1:0] COIN_NONE    = 2'd0;
    localparam logic [COIN_W-1:0] COIN_NICKEL  = 2'd1;
    localparam logic [COIN_W-1:0] COIN_DIME    = 2'd2;
    localparam logic [COIN_W-1:0] COIN_QUARTER = 2'd3;

    typedef enum logic [1:0] {
        VS_IDLE   = 2'd0,
        VS_VEND   = 2'd1,
        VS_CHANGE = 2'd2
    } vend_state_t;

    // Value of a coin code in nickel units.
    function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [COIN_W-1:0] code);
        case (code)
            COIN_NICKEL:  coin_value = 3'd1;
            COIN_DIME:    coin_value = 3'd2;
            COIN_QUARTER: coin_value = 3'd5;
            default:      coin_value = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_stock.sv
// Per-product stock counter: reloads on reset or restock, decrements on vend and
// saturates at zero.
module vend_stock #(
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               dec,
    input  logic               load,
    output logic [STOCK_W-1:0] count,
    output logic               empty
);

    // Load has priority so a restock on the vend cycle leaves a full slot.
    always_ff @(posedge clock) begin
        if (reset || load) begin
            count <= STOCK_W'(STOCK_INIT);
        end else if (dec && (count != '0)) begin
            count <= count - STOCK_W'(1);
        end
    end

    assign empty = (count == '0);

endmodule

// File: rtl/vend_controller.sv
// Multi-product vending controller: coin credit, lowest-index affordable selection,
// per-product stock. Define VEND_CHANGE_EN to return excess credit as nickel pulses.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned                        NUM_PRODUCTS = 3,
    parameter int unsigned                        CREDIT_W     = 8,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0]   PRICES       = {8'd5, 8'd5, 8'd5},
    parameter int unsigned                        STOCK_W      = 4,
    parameter int unsigned                        STOCK_INIT   = 15,
    localparam int unsigned                       ID_W         = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [COIN_W-1:0]       coin,
    input  logic [NUM_PRODUCTS-1:0] select,
    input  logic                    cancel,
    input  logic                    restock,
    input  logic [ID_W-1:0]         restock_id,
    output logic [NUM_PRODUCTS-1:0] vend,
    output logic [NUM_PRODUCTS-1:0] sold_out,
    output logic [CREDIT_W-1:0]     credit,
    output logic                    coin_reject,
    output logic                    change_out,
    output logic                    busy
);

    localparam logic [1:0] S_IDLE   = 2'(VS_IDLE);
    localparam logic [1:0] S_VEND   = 2'(VS_VEND);
`ifdef VEND_CHANGE_EN
    localparam logic [1:0] S_CHANGE = 2'(VS_CHANGE);
`endif

    logic [1:0]              state;
    logic [1:0]              state_next;
    logic [CREDIT_W-1:0]     credit_next;
    logic [NUM_PRODUCTS-1:0] vend_next;
    logic                    coin_reject_next;
    logic                    busy_next;
    logic [ID_W-1:0]         sel_idx;
    logic [ID_W-1:0]         sel_idx_next;
    logic [COIN_W-1:0]       coin_prev;

    logic                    coin_new;
    logic [CREDIT_W:0]       coin_sum;
    logic                    coin_ok;
    logic                    cand_found;
    logic [ID_W-1:0]         cand_idx;
    logic                    restock_hit;

    logic [CREDIT_W-1:0]     price       [NUM_PRODUCTS];
    logic [STOCK_W-1:0]      stock_count [NUM_PRODUCTS];
    logic [NUM_PRODUCTS-1:0] stock_empty;
    logic [NUM_PRODUCTS-1:0] stock_dec;
    logic [NUM_PRODUCTS-1:0] stock_load;

    // A coin counts only on a transition out of "no coin".
    assign coin_new    = (coin != COIN_NONE) && (coin_prev == COIN_NONE);
    assign coin_sum    = {1'b0, credit} + (CREDIT_W+1)'(coin_value(coin));
    assign coin_ok     = ~coin_sum[CREDIT_W];
    assign restock_hit = restock && (32'(restock_id) < NUM_PRODUCTS);

    for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_stock
        assign price[g]      = PRICES[g*CREDIT_W +: CREDIT_W];
        assign stock_dec[g]  = (state == S_VEND) && (sel_idx == ID_W'(g));
        assign stock_load[g] = restock_hit && (restock_id == ID_W'(g));

        vend_stock #(
            .STOCK_W    (STOCK_W),
            .STOCK_INIT (STOCK_INIT)
        ) u_stock (
            .clock (clock),
            .reset (reset),
            .dec   (stock_dec[g]),
            .load  (stock_load[g]),
            .count (stock_count[g]),
            .empty (stock_empty[g])
        );
    end

    assign sold_out = stock_empty;

    // Walk from the top index down so the lowest eligible index wins.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int i = int'(NUM_PRODUCTS) - 1; i >= 0; i--) begin
            if (select[i] && (credit >= price[i]) && (stock_count[i] != '0)) begin
                cand_found = 1'b1;
                cand_idx   = ID_W'(i);
            end
        end
    end

`ifdef VEND_CHANGE_EN
    logic change_out_next;
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign change_out    = 1'b0;
`endif

    // Next state and next registered outputs.
    always_comb begin
        state_next       = state;
        credit_next      = credit;
        vend_next        = '0;
        sel_idx_next     = sel_idx;
        coin_reject_next = 1'b0;
`ifdef VEND_CHANGE_EN
        change_out_next  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (coin_new) begin
                    if (coin_ok) begin
                        credit_next = coin_sum[CREDIT_W-1:0];
                    end else begin
                        coin_reject_next = 1'b1;
                    end
                end
                if (cand_found) begin
                    state_next          = S_VEND;
                    sel_idx_next        = cand_idx;
                    vend_next[cand_idx] = 1'b1;
                end
`ifdef VEND_CHANGE_EN
                else if (cancel && (credit != '0)) begin
                    state_next      = S_CHANGE;
                    change_out_next = 1'b1;
                end
`endif
            end
            S_VEND: begin
                coin_reject_next = coin_new;
                credit_next      = credit - price[sel_idx];
                state_next       = S_IDLE;
`ifdef VEND_CHANGE_EN
                if (credit_next != '0) begin
                    state_next      = S_CHANGE;
                    change_out_next = 1'b1;
                end
`endif
            end
`ifdef VEND_CHANGE_EN
            // The pulse in flight covers the nickel removed at this edge.
            S_CHANGE: begin
                coin_reject_next = coin_new;
                credit_next      = credit - CREDIT_W'(1);
                if (credit_next == '0) begin
                    state_next = S_IDLE;
                end else begin
                    change_out_next = 1'b1;
                end
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            credit      <= '0;
            vend        <= '0;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
            sel_idx     <= '0;
            coin_prev   <= COIN_NONE;
`ifdef VEND_CHANGE_EN
            change_out  <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            credit      <= credit_next;
            vend        <= vend_next;
            coin_reject <= coin_reject_next;
            busy        <= busy_next;
            sel_idx     <= sel_idx_next;
            coin_prev   <= coin;
`ifdef VEND_CHANGE_EN
            change_out  <= change_out_next;
`endif
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller with a 3-bit credit and prices {p2=5, p1=4, p0=5};
// expectations follow VEND_CHANGE_EN when it is defined for the build.
module tb_vend_controller;
    import vend_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] coin;
    logic [2:0] select;
    logic       cancel;
    logic       restock;
    logic [1:0] restock_id;
    logic [2:0] vend;
    logic [2:0] sold_out;
    logic [2:0] credit;
    logic       coin_reject;
    logic       change_out;
    logic       busy;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [1:0] coin;
        logic [2:0] sel;
        logic [2:0] e_vend;
        logic [2:0] e_credit;
        logic       e_rej;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    vend_controller #(
        .NUM_PRODUCTS (3),
        .CREDIT_W     (3),
        .PRICES       ({3'd5, 3'd4, 3'd5}),
        .STOCK_W      (4),
        .STOCK_INIT   (15)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .coin        (coin),
        .select      (select),
        .cancel      (cancel),
        .restock     (restock),
        .restock_id  (restock_id),
        .vend        (vend),
        .sold_out    (sold_out),
        .credit      (credit),
        .coin_reject (coin_reject),
        .change_out  (change_out),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] e_vend, input logic [2:0] e_credit,
                             input logic e_rej, input logic e_chg, input logic e_busy,
                             input logic [2:0] e_sold);
        chk({tag, ".vend"},        32'(vend),        32'(e_vend));
        chk({tag, ".credit"},      32'(credit),      32'(e_credit));
        chk({tag, ".coin_reject"}, 32'(coin_reject), 32'(e_rej));
        chk({tag, ".change_out"},  32'(change_out),  32'(e_chg));
        chk({tag, ".busy"},        32'(busy),        32'(e_busy));
        chk({tag, ".sold_out"},    32'(sold_out),    32'(e_sold));
    endtask

    // Apply inputs for one clock, then sample just after the edge.
    task automatic drive(input logic [1:0] c, input logic [2:0] s, input logic cn,
                         input logic rs, input logic [1:0] rid);
        coin       = c;
        select     = s;
        cancel     = cn;
        restock    = rs;
        restock_id = rid;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(COIN_NONE, 3'b000, 1'b0, 1'b0, 2'd0);
        drive(COIN_NONE, 3'b000, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
    endtask

    task automatic add(input logic [1:0] c, input logic [2:0] s, input logic [2:0] v,
                       input logic [2:0] cr, input logic r, input logic b);
        vec_t e;
        e.coin = c; e.sel = s; e.e_vend = v; e.e_credit = cr; e.e_rej = r; e.e_busy = b;
        tbl.push_back(e);
    endtask

    // Buy product 0 with an exact quarter; optionally restock product 0 on the vend cycle.
    task automatic buy_p0(input logic rs_on_vend);
        drive(COIN_QUARTER, 3'b000, 1'b0, 1'b0, 2'd0);
        drive(COIN_NONE,    3'b000, 1'b0, 1'b0, 2'd0);
        drive(COIN_NONE,    3'b001, 1'b0, 1'b0, 2'd0);
        chk("buy_p0.vend", 32'(vend), 32'(3'b001));
        drive(COIN_NONE,    3'b000, 1'b0, rs_on_vend, 2'd0);
        chk("buy_p0.credit", 32'(credit), 32'd0);
    endtask

    initial begin
        reset = 1'b1; coin = COIN_NONE; select = '0; cancel = 1'b0; restock = 1'b0; restock_id = '0;
        do_reset();
        check_out("reset", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);

        //    coin          sel     vend    credit rej busy
        add(COIN_DIME,    3'b000, 3'b000, 3'd2, 1'b0, 1'b0);
        add(COIN_NONE,    3'b000, 3'b000, 3'd2, 1'b0, 1'b0);
        add(COIN_DIME,    3'b000, 3'b000, 3'd4, 1'b0, 1'b0);
        add(COIN_NONE,    3'b000, 3'b000, 3'd4, 1'b0, 1'b0);
        add(COIN_NICKEL,  3'b001, 3'b000, 3'd5, 1'b0, 1'b0);
        add(COIN_NONE,    3'b001, 3'b001, 3'd5, 1'b0, 1'b1);
        add(COIN_NICKEL,  3'b000, 3'b000, 3'd0, 1'b1, 1'b0);
        add(COIN_NONE,    3'b000, 3'b000, 3'd0, 1'b0, 1'b0);
        add(COIN_DIME,    3'b000, 3'b000, 3'd2, 1'b0, 1'b0);
        add(COIN_DIME,    3'b000, 3'b000, 3'd2, 1'b0, 1'b0);
        add(COIN_NONE,    3'b000, 3'b000, 3'd2, 1'b0, 1'b0);
        add(COIN_DIME,    3'b000, 3'b000, 3'd4, 1'b0, 1'b0);
        add(COIN_NONE,    3'b011, 3'b010, 3'd4, 1'b0, 1'b1);
        add(COIN_NONE,    3'b000, 3'b000, 3'd0, 1'b0, 1'b0);
        add(COIN_NICKEL,  3'b000, 3'b000, 3'd1, 1'b0, 1'b0);
        add(COIN_NICKEL,  3'b000, 3'b000, 3'd1, 1'b0, 1'b0);
        add(COIN_NICKEL,  3'b000, 3'b000, 3'd1, 1'b0, 1'b0);
        add(COIN_DIME,    3'b000, 3'b000, 3'd1, 1'b0, 1'b0);
        add(COIN_QUARTER, 3'b000, 3'b000, 3'd1, 1'b0, 1'b0);
        add(COIN_NONE,    3'b000, 3'b000, 3'd1, 1'b0, 1'b0);
        add(COIN_DIME,    3'b000, 3'b000, 3'd3, 1'b0, 1'b0);
        add(COIN_NONE,    3'b000, 3'b000, 3'd3, 1'b0, 1'b0);
        add(COIN_NICKEL,  3'b000, 3'b000, 3'd4, 1'b0, 1'b0);
        add(COIN_NONE,    3'b000, 3'b000, 3'd4, 1'b0, 1'b0);
        add(COIN_NICKEL,  3'b000, 3'b000, 3'd5, 1'b0, 1'b0);
        add(COIN_NONE,    3'b000, 3'b000, 3'd5, 1'b0, 1'b0);
        add(COIN_QUARTER, 3'b000, 3'b000, 3'd5, 1'b1, 1'b0);
        add(COIN_NONE,    3'b000, 3'b000, 3'd5, 1'b0, 1'b0);
        add(COIN_DIME,    3'b000, 3'b000, 3'd7, 1'b0, 1'b0);
        add(COIN_NONE,    3'b000, 3'b000, 3'd7, 1'b0, 1'b0);
        add(COIN_NICKEL,  3'b000, 3'b000, 3'd7, 1'b1, 1'b0);
        add(COIN_NONE,    3'b000, 3'b000, 3'd7, 1'b0, 1'b0);

        foreach (tbl[k]) begin
            drive(tbl[k].coin, tbl[k].sel, 1'b0, 1'b0, 2'd0);
            check_out($sformatf("vec%0d", k), tbl[k].e_vend, tbl[k].e_credit,
                      tbl[k].e_rej, 1'b0, tbl[k].e_busy, 3'b000);
        end

        // Three dimes, buy product 2 (price 5), one nickel of excess.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(COIN_DIME, 3'b000, 1'b0, 1'b0, 2'd0);
            drive(COIN_NONE, 3'b000, 1'b0, 1'b0, 2'd0);
        end
        chk("dimes.credit", 32'(credit), 32'd6);
        drive(COIN_NONE, 3'b100, 1'b0, 1'b0, 2'd0);
        check_out("dimes.vend", 3'b100, 3'd6, 1'b0, 1'b0, 1'b1, 3'b000);
        drive(COIN_NONE, 3'b000, 1'b0, 1'b0, 2'd0);
`ifdef VEND_CHANGE_EN
        check_out("dimes.change", 3'b000, 3'd1, 1'b0, 1'b1, 1'b1, 3'b000);
        drive(COIN_NONE, 3'b000, 1'b0, 1'b0, 2'd0);
        check_out("dimes.idle", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);
`else
        check_out("dimes.keep", 3'b000, 3'd1, 1'b0, 1'b0, 1'b0, 3'b000);
`endif

        // Three nickels then a held cancel.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(COIN_NICKEL, 3'b000, 1'b0, 1'b0, 2'd0);
            drive(COIN_NONE,   3'b000, 1'b0, 1'b0, 2'd0);
        end
        chk("cancel.credit", 32'(credit), 32'd3);
`ifdef VEND_CHANGE_EN
        for (int k = 0; k < 3; k++) begin
            drive(COIN_NONE, 3'b000, 1'b1, 1'b0, 2'd0);
            check_out($sformatf("cancel.chg%0d", k), 3'b000, 3'(3 - k), 1'b0, 1'b1, 1'b1, 3'b000);
        end
        drive(COIN_NONE, 3'b000, 1'b1, 1'b0, 2'd0);
        check_out("cancel.done", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        drive(COIN_NONE, 3'b000, 1'b1, 1'b0, 2'd0);
        check_out("cancel.idle", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);
`else
        for (int k = 0; k < 2; k++) begin
            drive(COIN_NONE, 3'b000, 1'b1, 1'b0, 2'd0);
            check_out($sformatf("cancel.ignored%0d", k), 3'b000, 3'd3, 1'b0, 1'b0, 1'b0, 3'b000);
        end
`endif

        // Stock depletion, restock racing a vend, and an out-of-range restock.
        do_reset();
        for (int k = 0; k < 14; k++) buy_p0(1'b0);
        chk("drain14.sold_out", 32'(sold_out), 32'(3'b000));
        buy_p0(1'b1);
        chk("restock_vs_vend.sold_out", 32'(sold_out), 32'(3'b000));
        for (int k = 0; k < 14; k++) buy_p0(1'b0);
        chk("refill14.sold_out", 32'(sold_out), 32'(3'b000));
        buy_p0(1'b0);
        chk("refill15.sold_out", 32'(sold_out), 32'(3'b001));
        drive(COIN_NONE, 3'b000, 1'b0, 1'b1, 2'd3);
        chk("restock_bad_id.sold_out", 32'(sold_out), 32'(3'b001));
        drive(COIN_QUARTER, 3'b000, 1'b0, 1'b0, 2'd0);
        drive(COIN_NONE,    3'b000, 1'b0, 1'b0, 2'd0);
        chk("skip.credit", 32'(credit), 32'd5);
        drive(COIN_NONE, 3'b011, 1'b0, 1'b0, 2'd0);
        check_out("skip.vend", 3'b010, 3'd5, 1'b0, 1'b0, 1'b1, 3'b001);
        drive(COIN_NONE, 3'b000, 1'b0, 1'b0, 2'd0);
`ifdef VEND_CHANGE_EN
        check_out("skip.change", 3'b000, 3'd1, 1'b0, 1'b1, 1'b1, 3'b001);
        drive(COIN_NONE, 3'b000, 1'b0, 1'b0, 2'd0);
        check_out("skip.idle", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 3'b001);

        // Reset on the second change cycle.
        for (int k = 0; k < 3; k++) begin
            drive(COIN_NICKEL, 3'b000, 1'b0, 1'b0, 2'd0);
            drive(COIN_NONE,   3'b000, 1'b0, 1'b0, 2'd0);
        end
        drive(COIN_NONE, 3'b000, 1'b1, 1'b0, 2'd0);
        check_out("abort.chg0", 3'b000, 3'd3, 1'b0, 1'b1, 1'b1, 3'b001);
        drive(COIN_NONE, 3'b000, 1'b0, 1'b0, 2'd0);
        check_out("abort.chg1", 3'b000, 3'd2, 1'b0, 1'b1, 1'b1, 3'b001);
`else
        check_out("skip.keep", 3'b000, 3'd1, 1'b0, 1'b0, 1'b0, 3'b001);

        // Reset during a vend cycle.
        drive(COIN_QUARTER, 3'b000, 1'b0, 1'b0, 2'd0);
        drive(COIN_NONE,    3'b000, 1'b0, 1'b0, 2'd0);
        drive(COIN_NONE,    3'b010, 1'b0, 1'b0, 2'd0);
        check_out("abort.vend", 3'b010, 3'd6, 1'b0, 1'b0, 1'b1, 3'b001);
`endif
        reset = 1'b1;
        drive(COIN_NONE, 3'b000, 1'b0, 1'b0, 2'd0);
        check_out("abort.reset", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        reset = 1'b0;
        drive(COIN_NONE, 3'b000, 1'b0, 1'b0, 2'd0);
        check_out("abort.after", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
